// File: rtl/masked_share_decoder_pkg.sv
// masked_share_decoder_pkg: shared FSM state type and counter-width helper for the share decoder
package masked_share_decoder_pkg;
   typedef enum logic [1:0] {ACCUM, HOLD, DRAIN} dec_state_t;
   function automatic int cnt_w(input int nshares);
      return $clog2(nshares + 1);
   endfunction
endpackage

// File: rtl/masked_share_decoder_if.sv
// masked_share_decoder_if: share-beat input stream and recombined-word output stream
//   s_valid/s_ready/s_share/s_last : share beats into the decoder
//   m_valid/m_ready/m_data/m_err   : recombined word out of the decoder
//   slave modport = decoder side, master modport = producer/consumer side
interface masked_share_decoder_if #(parameter int WIDTH = 64);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_share;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_err;
   modport slave (input s_valid, s_share, s_last, m_ready, output s_ready, m_valid, m_data, m_err);
   modport master (output s_valid, s_share, s_last, m_ready, input s_ready, m_valid, m_data, m_err);
endinterface

// File: rtl/masked_share_decoder_share_accumulator.sv
// share_accumulator: XOR accumulator plus beat counter for one share group
//   clk, rst : clock, async active-high reset
//   clr      : zero acc and count (wins over en)
//   en       : fold share into acc and count the beat
//   share    : incoming share
//   acc_next : acc ^ share, the group result if this beat closes it
//   cnt_hit  : this beat would be share number NSHARES
module share_accumulator
   import masked_share_decoder_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int NSHARES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] share,
   output logic [WIDTH-1:0] acc_next,
   output logic             cnt_hit
);
   localparam int CW = cnt_w(NSHARES);
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   always_comb begin
      acc_next = acc_q ^ share;
      cnt_hit  = (cnt_q + CW'(1)) == CW'(NSHARES);
      acc_d    = clr ? '0 : en ? acc_next : acc_q;
      cnt_d    = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/masked_share_decoder.sv
// masked_share_decoder: XOR-recombines serial Boolean shares into the unmasked word
//   clk, rst : clock, async active-high reset
//   bus      : slave side of masked_share_decoder_if (share beats in, word + m_err out)
// A group ends on s_last or on the NSHARES-th beat; an overlong group is reported
// with m_err and its remaining beats are swallowed in DRAIN up to s_last.
module masked_share_decoder
   import masked_share_decoder_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int NSHARES = 3
) (
   input logic                  clk,
   input logic                  rst,
   masked_share_decoder_if.slave bus
);
   dec_state_t       state_q, state_d;
   logic             m_valid_q, m_valid_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic             m_err_q, m_err_d;
   logic             drain_pend_q, drain_pend_d;
   logic             acc_clr, acc_en, cnt_hit, beat;
   logic [WIDTH-1:0] acc_next;
   share_accumulator #(.WIDTH(WIDTH), .NSHARES(NSHARES)) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .en       (acc_en),
      .share    (bus.s_share),
      .acc_next (acc_next),
      .cnt_hit  (cnt_hit)
   );
   assign bus.s_ready = state_q != HOLD;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_err   = m_err_q;
   assign beat        = bus.s_valid && bus.s_ready;
   always_comb begin
      state_d      = state_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_err_d      = m_err_q;
      drain_pend_d = drain_pend_q;
      acc_clr      = 1'b0;
      acc_en       = 1'b0;
      case (state_q)
         ACCUM: if (beat) begin
            acc_en = 1'b1;
            if (bus.s_last || cnt_hit) begin
               // without s_last, hitting NSHARES means the group is overlong
               m_valid_d    = 1'b1;
               m_data_d     = acc_next;
               m_err_d      = bus.s_last ? !cnt_hit : 1'b1;
               drain_pend_d = !bus.s_last;
               acc_clr      = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: if (bus.m_ready) begin
            // scrub the plain word off the bus once it is taken
            m_valid_d    = 1'b0;
            m_data_d     = '0;
            m_err_d      = 1'b0;
            drain_pend_d = 1'b0;
            state_d      = drain_pend_q ? DRAIN : ACCUM;
         end
         DRAIN: if (beat && bus.s_last) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ACCUM;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_err_q      <= 1'b0;
         drain_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_err_q      <= m_err_d;
         drain_pend_q <= drain_pend_d;
      end
   end
endmodule

// File: tb/tb_masked_share_decoder.sv
// tb_masked_share_decoder: directed and randomised checks of the 3-share, 64-bit decoder
module tb_masked_share_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;
   logic [63:0] vals [1000];
   masked_share_decoder_if #(.WIDTH(64)) bus ();
   masked_share_decoder #(.WIDTH(64), .NSHARES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic send_beat(input logic [63:0] sh, input logic lst);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_share = sh;
      bus.s_last  = lst;
      while (!bus.s_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.s_ready) chk("s_ready_wait", bus.s_ready, 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask
   task automatic expect_word(input string tag, input logic [63:0] data, input logic err, input int dly);
      int n = 0;
      while (!bus.m_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (dly) begin
         @(posedge clk); #1;
      end
      chk({tag, "_valid"}, bus.m_valid, 1);
      chk({tag, "_data"}, bus.m_data, data);
      chk({tag, "_err"}, bus.m_err, err);
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
   endtask
   initial begin
      bus.s_valid = 1'b0;
      bus.s_share = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      #2;
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_m_err", bus.m_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      // basic group with m_ready held high
      bus.m_ready = 1'b1;
      send_beat(64'hA5, 0);
      send_beat(64'h0F, 0);
      send_beat(64'hFF, 1);
      chk("t1_valid", bus.m_valid, 1);
      chk("t1_data", bus.m_data, 64'h55);
      chk("t1_err", bus.m_err, 0);
      chk("t1_s_ready_hold", bus.s_ready, 0);
      @(posedge clk); #1;
      chk("t1_valid_drop", bus.m_valid, 0);
      chk("t1_data_clr", bus.m_data, 0);
      chk("t1_s_ready", bus.s_ready, 1);
      bus.m_ready = 1'b0;
      // backpressure, junk beats offered while s_ready is low
      send_beat(64'hA5, 0);
      send_beat(64'h0F, 0);
      send_beat(64'hFF, 1);
      bus.s_valid = 1'b1;
      bus.s_share = 64'hDEAD;
      bus.s_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid", bus.m_valid, 1);
         chk("t2_data", bus.m_data, 64'h55);
         chk("t2_s_ready", bus.s_ready, 0);
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      chk("t2_valid_drop", bus.m_valid, 0);
      // short group
      send_beat(64'h12, 0);
      send_beat(64'h34, 1);
      expect_word("t3", 64'h26, 1, 0);
      // single-beat group
      send_beat(64'h5A, 1);
      expect_word("t3b", 64'h5A, 1, 0);
      // overrun then drain
      send_beat(64'h1, 0);
      send_beat(64'h2, 0);
      send_beat(64'h4, 0);
      expect_word("t4", 64'h7, 1, 0);
      chk("t4_drain_ready", bus.s_ready, 1);
      send_beat(64'h8, 1);
      @(posedge clk); #1;
      chk("t4_drain_quiet", bus.m_valid, 0);
      send_beat(64'h3, 0);
      send_beat(64'h3, 0);
      send_beat(64'h3, 1);
      expect_word("t4b", 64'h3, 0, 0);
      // reset mid-group
      send_beat(64'h1, 0);
      send_beat(64'h2, 0);
      rst = 1'b1;
      #1;
      chk("t5_s_ready", bus.s_ready, 1);
      chk("t5_m_valid", bus.m_valid, 0);
      chk("t5_m_data", bus.m_data, 0);
      chk("t5_m_err", bus.m_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      send_beat(64'h1, 0);
      send_beat(64'h1, 0);
      send_beat(64'h1, 1);
      expect_word("t5", 64'h1, 0, 0);
      // reset between edges while a word is held
      send_beat(64'h77, 0);
      send_beat(64'h11, 0);
      send_beat(64'h22, 1);
      chk("t5b_held", bus.m_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5b_async_valid", bus.m_valid, 0);
      chk("t5b_async_data", bus.m_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      // random values split into shares, random gaps on both sides
      for (int i = 0; i < 1000; i++) vals[i] = {$urandom, $urandom};
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [63:0] r1, r2;
               r1 = {$urandom, $urandom};
               r2 = {$urandom, $urandom};
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk); #1;
               end
               send_beat(r1, 0);
               repeat ($urandom_range(0, 1)) begin
                  @(posedge clk); #1;
               end
               send_beat(r2, 0);
               send_beat(vals[i] ^ r1 ^ r2, 1);
            end
         end
         begin
            for (int k = 0; k < 1000; k++) expect_word("t6", vals[k], 0, $urandom_range(0, 2));
         end
      join
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
